// File: rtl/div_rv.sv
// div_rv: iterative radix-2 restoring divider for RV DIV/DIVU/REM/REMU on WIDTH-bit operands.
// Optional build macro DIV_EARLY_OUT_EN adds single-cycle shortcuts for |divisor|=1 and |dividend|<|divisor|.
module div_rv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken on a cpu_clk edge with in_valid & in_ready (IDLE only);
  // a result leaves on an edge with out_valid & out_ready, out_result held stable until then.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dsor;
  logic [WIDTH:0]     rem;

  logic               is_signed;
  logic               src1_neg;
  logic               src2_neg;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               div_zero;
  logic               ovf;
  logic               special;
  logic [WIDTH-1:0]   special_res;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // The most-negative value negates to itself, which is already its correct unsigned magnitude.
  assign is_signed = ~in_op[0];
  assign src1_neg  = is_signed & in_src1[WIDTH-1];
  assign src2_neg  = is_signed & in_src2[WIDTH-1];
  assign mag1      = src1_neg ? -in_src1 : in_src1;
  assign mag2      = src2_neg ? -in_src2 : in_src2;
  assign div_zero  = (in_src2 == '0);
  assign ovf       = is_signed & (in_src1 == MIN_VAL) & (&in_src2);

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (div_zero) begin
      special     = 1'b1;
      special_res = in_op[1] ? in_src1 : '1;
    end else if (ovf) begin
      special     = 1'b1;
      special_res = in_op[1] ? '0 : in_src1;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (mag2 == WIDTH'(1)) begin
      special     = 1'b1;
      special_res = in_op[1] ? '0 : ((src1_neg ^ src2_neg) ? -mag1 : mag1);
    end else if (mag1 < mag2) begin
      special     = 1'b1;
      special_res = in_op[1] ? in_src1 : '0;
    end
`endif
  end

  // quo doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom.
  assign trial = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff  = trial - {1'b0, dsor};
  assign ge    = (trial >= {1'b0, dsor});
  assign quo_f = q_neg ? -quo : quo;
  assign rem_f = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      op_q       <= 2'b00;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      quo        <= '0;
      dsor       <= '0;
      rem        <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            q_neg <= src1_neg ^ src2_neg;
            r_neg <= src1_neg;
            quo   <= mag1;
            dsor  <= mag2;
            rem   <= '0;
            cnt   <= '0;
            if (special) begin
              out_result <= special_res;
              state      <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= ge ? diff : trial;
          quo <= {quo[WIDTH-2:0], ge};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          out_result <= op_q[1] ? rem_f : quo_f;
          state      <= S_DONE;
        end
        S_DONE: begin
          // out_valid rises one edge after entering DONE, so the result is already settled.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rv.sv
// tb_div_rv: directed and randomized checks of div_rv against a plain-arithmetic reference model.
// Honours DIV_EARLY_OUT_EN in its latency expectations.
module tb_div_rv;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'd0;
  logic [W-1:0] in_src1 = '0;
  logic [W-1:0] in_src2 = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  div_rv #(.WIDTH(W)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      if (a == MIN_VAL && b == '1) return op[1] ? '0 : a;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic int lat_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
    if (!op[0] && a == MIN_VAL && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
    begin
      longint m1, m2;
      m1 = op[0] ? longint'(a) : longint'($signed(a));
      m2 = op[0] ? longint'(b) : longint'($signed(b));
      if (m1 < 0) m1 = -m1;
      if (m2 < 0) m2 = -m2;
      if (m2 == 1 || m1 < m2) return 1;
    end
`endif
    return W + 2;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    @(negedge cpu_clk);
    check({tag, " in_ready_before"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    in_src1  = $urandom;
    in_src2  = $urandom;
    in_op    = 2'($urandom_range(0, 3));
    exp_q.push_back(exp);
    lat_q.push_back(lat_model(op, a, b));
  endtask

  task automatic collect(input string tag, input int hold);
    int cyc = 0;
    logic [W-1:0] exp;
    int lat;
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge cpu_clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, W'(cyc), W'(lat));
    check({tag, " result"}, out_result, exp);
    check({tag, " in_ready_busy"}, W'(in_ready), W'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge cpu_clk);
      #1;
      check({tag, " hold_valid"}, W'(out_valid), W'(1));
      check({tag, " hold_result"}, out_result, exp);
    end
    @(negedge cpu_clk);
    out_ready = 1'b1;
    @(posedge cpu_clk);
    #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, W'(out_valid), W'(0));
    check({tag, " in_ready_after"}, W'(in_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
    issue(tag, op, a, b, exp);
    collect(tag, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] dummy;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    int           seen;

    // reset
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst out_result", out_result, '0);
    check("rst busy", W'(busy), W'(0));
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(posedge cpu_clk);
    #1;
    check("rst in_ready", W'(in_ready), W'(1));

    // directed values from the test plan
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", OP_DIV, MIN_VAL, 32'hFFFF_FFFF, MIN_VAL, 0);
    run_op("rem_ovf", OP_REM, MIN_VAL, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, 0);
    run_op("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, 0);
    run_op("div_min_2", OP_DIV, MIN_VAL, 32'd2, 32'hC000_0000, 0);
    run_op("rem_min_3", OP_REM, MIN_VAL, 32'd3, 32'hFFFF_FFFE, 0);
    run_op("div_m9_m1", OP_DIV, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd9, 0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);

    // backpressure
    run_op("bp_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 10);

    // flush in the middle of CALC
    issue("flush_calc", OP_DIVU, 32'd12345, 32'd67, 32'd0);
    dummy = exp_q.pop_front();
    void'(lat_q.pop_front());
    repeat (10) @(posedge cpu_clk);
    #1;
    check("flush busy_before", W'(busy), W'(1));
    @(negedge cpu_clk);
    flush = 1'b1;
    @(posedge cpu_clk);
    #1;
    flush = 1'b0;
    check("flush in_ready", W'(in_ready), W'(1));
    check("flush busy", W'(busy), W'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge cpu_clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush no_result", W'(seen), W'(0));
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd10, 32'd100, 0);

    // flush beats accept in IDLE
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_op    = OP_DIVU;
    in_src1  = 32'd50;
    in_src2  = 32'd5;
    flush    = 1'b1;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_accept busy", W'(busy), W'(0));

    // flush beats the output handshake in DONE
    issue("flush_done", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    dummy = exp_q.pop_front();
    void'(lat_q.pop_front());
    @(posedge cpu_clk);
    #1;
    check("flush_done valid", W'(out_valid), W'(1));
    @(negedge cpu_clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge cpu_clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done valid_drop", W'(out_valid), W'(0));
    check("flush_done in_ready", W'(in_ready), W'(1));

    // reset mid-operation
    issue("rst_mid", OP_DIV, 32'd999, 32'd3, 32'd0);
    dummy = exp_q.pop_front();
    void'(lat_q.pop_front());
    repeat (5) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(posedge cpu_clk);
    #1;
    check("rst_mid out_valid", W'(out_valid), W'(0));
    check("rst_mid out_result", out_result, '0);
    check("rst_mid busy", W'(busy), W'(0));
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(posedge cpu_clk);
    #1;
    check("rst_mid in_ready", W'(in_ready), W'(1));

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(1, 40)); end
        2: begin a = $urandom; b = '0; end
        3: begin a = MIN_VAL; b = ($urandom_range(0, 1) == 1) ? '1 : 32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = ($urandom_range(0, 1) == 1) ? 32'd1 : '1; end
      endcase
      run_op("rand", op, a, b, ref_model(op, a, b), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_rv.md
# div_rv

Parametrised iterative divider for the RV M-extension, the successor of the fixed 32-bit unsigned divider. It executes DIV, DIVU, REM and REMU on WIDTH-bit operands using a radix-2 restoring algorithm on operand magnitudes, followed by a sign-fix step. It sits in the execute stage beside the multiplier. It connects to the pipeline through valid/ready on both input and output, and has a flush input for pipeline kills.

## Interface
- WIDTH, 32: operand/result width (≥ 4).
- CNT_W, $clog2(WIDTH+1): iteration counter width.
- cpu_clk  in  1  cpu clock; all state on rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- in_op  in  2  equals funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_src1  in  WIDTH  dividend.
- in_src2  in  WIDTH  divisor.
- flush  in  1  abort current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  quotient or remainder per captured op.
- busy  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: accept on in_valid&in_ready; capture op, result sign flags, |src1|, |src2| (magnitudes only for signed ops).
  - CALC: one quotient bit per cycle, MSB first; partial remainder WIDTH+1 bits; subtract when ≥ divisor.
  - FIX: negate quotient if signs differ; negate remainder if dividend negative; select quotient or remainder into out_result.
  - DONE: out_valid=1; out_result stable until handshake.
- Transitions:
  - IDLE→CALC on accept (normal case).
  - IDLE→DONE on accept (special case, result computed at accept).
  - CALC→FIX when counter = WIDTH−1.
  - FIX→DONE.
  - DONE→IDLE on out_valid&out_ready.
- Special cases (always single-cycle):
  - Divisor 0: quotient all-ones; remainder = src1 (signed and unsigned).
  - Signed overflow, src1 = 1<<(WIDTH−1) and src2 = all-ones: quotient = src1; remainder 0.
- Magnitude of most-negative value is 1<<(WIDTH−1), handled correctly in WIDTH+1-bit remainder.
- Operands are captured; in_src* may change after accept.

## Timing
- Reset (cpu_rst=1 at edge): state IDLE, out_valid 0, out_result 0, counter 0, busy 0. in_ready=1 the first cycle after reset deasserts.
- Normal latency: out_valid rises WIDTH+2 edges after the accept edge (WIDTH CALC + 1 FIX + registered DONE): 34 for WIDTH=32.
- Special/early-out latency: out_valid one edge after accept.
- No back-to-back issue: in_ready returns the cycle after the output handshake.
- out_ready low: DONE held indefinitely, result unchanged.
- flush: any state→IDLE at next edge, out_valid drops, counter cleared, no result delivered. Priority over accept and over the output handshake in the same cycle.
- cpu_rst mid-operation: same effect as flush plus reset values.
- in_valid while busy: ignored (in_ready=0).

## Configuration
- DIV_EARLY_OUT_EN defined: additional single-cycle shortcuts at accept:
  - |src2| = 1: quotient = ±src1 with sign fix; remainder 0.
  - |src1| < |src2|: quotient 0; remainder = src1.
- DIV_EARLY_OUT_EN undefined: these cases run the full WIDTH+2 latency with identical results. Divide-by-zero and overflow stay single-cycle either way.

## Test plan
- DIVU 100/7, WIDTH=32 → out_result 14 at 34 cycles after accept; REMU same operands → 2.
- REM 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFF (−1); DIV same operands → 0xFFFFFFFD (−3); DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, both 1-cycle; DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, 1-cycle.
- Backpressure: out_ready held low 10 cycles after out_valid → out_result constant, in_ready 0; handshake → in_ready 1 next cycle.
- Flush at CALC cycle 10 → out_valid never asserts, in_ready 1 next cycle. The next DIVU 1000/10 → 100.
- DIVU 3/10: macro defined → 0 after 1 cycle; undefined → 0 after 34 cycles. REMU 3/10 → 3 in both builds.
